// File: rtl/seq_shift_add_mult_if.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult_if
//   Start/done handshake bundle for the sequential shift-and-add multiplier.
//
//   Parameter
//     N        operand width; the product is 2N bits wide
//
//   Signals
//     start    requester -> multiplier   request, sampled only while idle
//     a        requester -> multiplier   multiplicand, captured on acceptance
//     b        requester -> multiplier   multiplier, captured on acceptance
//     busy     multiplier -> requester   operation in progress
//     done     multiplier -> requester   one-cycle completion pulse
//     product  multiplier -> requester   registered 2N-bit result
//
//   Modports
//     master   the requester side
//     slave    the multiplier side
// -----------------------------------------------------------------------------
interface seq_shift_add_mult_if #(
    parameter int N = 16
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//   Sequential unsigned shift-and-add multiplier, N x N -> 2N. One partial sum
//   is formed per clock by a ripple-carry adder (rca_nbit), so an operation
//   spends N cycles in RUN followed by one DONE cycle. The result register
//   holds its value until the next operation completes.
//
//   Ports
//     clk      system clock, rising edge
//     reset    asynchronous, active-high; clears all state
//     bus      seq_shift_add_mult_if.slave
//                start/a/b in, busy/done/product out
//
//   Build option
//     ZERO_BYPASS_EN  when defined, an accepted request with a zero operand
//                     skips RUN and completes one cycle after acceptance with
//                     product 0. When undefined, every operation runs the
//                     full N cycles and no zero-detect logic exists.
//
//   Also in this file
//     rca_nbit   n-bit ripple-carry adder used for the partial sums
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// rca_nbit
//   Plain n-bit ripple-carry adder: {c_out, s} = x + y + c_in.
//
//   Ports
//     x, y     n-bit addends
//     c_in     carry in
//     s        n-bit sum
//     c_out    carry out of the MSB
// -----------------------------------------------------------------------------
module rca_nbit #(
    parameter int n = 16
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         c_in,
    output logic [n-1:0] s,
    output logic         c_out
);
    logic [n:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < n; i++) begin : g_bit
        assign s[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign c_out = carry[n];
endmodule

module seq_shift_add_mult #(
    parameter int N = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_shift_add_mult_if.slave   bus
);
    localparam int COUNT_W = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e               state_q,   state_d;
    logic [N-1:0]         acc_hi_q,  acc_hi_d;
    logic [N-1:0]         mcand_q,   mcand_d;
    logic [N-1:0]         mplier_q,  mplier_d;
    logic [COUNT_W-1:0]   count_q,   count_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [2*N-1:0]       product_q, product_d;

    // Partial-sum datapath: add the multiplicand into the upper half when the
    // current multiplier LSB is set.
    logic [N-1:0]         addend;
    logic [N-1:0]         sum;
    logic                 sum_carry;
    logic [2*N-1:0]       shifted;

    assign addend = mplier_q[0] ? mcand_q : '0;

    rca_nbit #(.n(N)) u_rca (
        .x     (acc_hi_q),
        .y     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (sum_carry)
    );

    // The adder carry lands in the accumulator MSB after the right shift, so
    // no bit of the product is ever lost. The consumed multiplier LSB falls
    // off the bottom while product bits fill in from above.
    assign shifted = {sum_carry, sum, mplier_q[N-1:1]};

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        acc_hi_d  = acc_hi_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_hi_d = '0;
                    count_d  = '0;
`ifdef ZERO_BYPASS_EN
                    if (bus.a == '0 || bus.b == '0) begin
                        state_d   = DONE;
                        product_d = '0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
`else
                    state_d = RUN;
                    busy_d  = 1'b1;
`endif
                end
            end

            RUN: begin
                {acc_hi_d, mplier_d} = shifted;
                count_d              = count_q + COUNT_W'(1);
                if (count_q == COUNT_W'(N - 1)) begin
                    // Product is taken from the final shifted value so it is
                    // complete on the same edge that enters DONE.
                    state_d   = DONE;
                    product_d = shifted;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end

            DONE: begin
                // A start seen here is ignored; requests are only accepted
                // from IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: all state, datapath registers included, is cleared by the async
    // reset so an interrupted operation leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_hi_q  <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_mult
//   Directed bench for seq_shift_add_mult (N = 16). Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_shift_add_mult;
    localparam int N       = 16;
    localparam int TIMEOUT = 200;

    logic clk;
    logic reset;

    int checks;
    int errors;

    seq_shift_add_mult_if #(.N(N)) bus ();

    seq_shift_add_mult #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for done, counting rising edges from the current
    // falling edge and how many sampled cycles had busy low. Returns on the
    // falling edge where done is seen, or after TIMEOUT edges.
    task automatic wait_done(output int cyc, output int busy_low);
        cyc      = 0;
        busy_low = 0;
        while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
            if (bus.busy !== 1'b1) busy_low++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    // Issues one single-cycle start pulse and waits for completion.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                          output logic [2*N-1:0] p, output int cyc,
                          output int busy_low);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc, busy_low);
        p = bus.product;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 0",
                     bus.busy, bus.done, bus.product);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        logic [2*N-1:0] p;
        int cyc, busy_low;
        run_op(16'd3, 16'd5, p, cyc, busy_low);
        checks++;
        if (cyc !== N) begin
            errors++;
            $display("FAIL basic_latency: %0d edges after accept, want %0d", cyc, N);
        end
        checks++;
        if (busy_low !== 0) begin
            errors++;
            $display("FAIL basic_busy: busy low in %0d RUN cycles, want 0", busy_low);
        end
        checks++;
        if (p !== 32'd15) begin
            errors++;
            $display("FAIL basic_product: got %0d, want 15", p);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_at_done: busy=%b, want 0", bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.product !== 32'd15) begin
            errors++;
            $display("FAIL basic_pulse_hold: done=%b product=%0d, want 0 15",
                     bus.done, bus.product);
        end
    endtask

    task automatic test_max();
        logic [2*N-1:0] p;
        int cyc, busy_low;
        run_op(16'hFFFF, 16'hFFFF, p, cyc, busy_low);
        checks++;
        if (p !== 32'hFFFE0001 || cyc !== N) begin
            errors++;
            $display("FAIL max_product: got %h after %0d edges, want fffe0001 after %0d",
                     p, cyc, N);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL max_single_pulse: done=%b, want 0", bus.done);
        end
    endtask

    // start held high for the whole operation while a/b keep changing.
    task automatic test_start_held();
        int cyc, busy_low;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd7;
        bus.b     = 16'd6;
        @(posedge clk);
        @(negedge clk);
        cyc      = 0;
        busy_low = 0;
        while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
            if (bus.busy !== 1'b1) busy_low++;
            bus.a = bus.a + 16'd3;
            bus.b = bus.b + 16'd5;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (bus.product !== 32'd42 || cyc !== N || busy_low !== 0) begin
            errors++;
            $display("FAIL held_start: product=%0d edges=%0d busy_low=%0d, want 42 %0d 0",
                     bus.product, cyc, busy_low, N);
        end
        // start still high across the DONE->IDLE edge must not launch an op.
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [2*N-1:0] p;
        int cyc, busy_low;
        int want_cyc;
`ifdef ZERO_BYPASS_EN
        want_cyc = 0;
`else
        want_cyc = N;
`endif
        run_op(16'h0000, 16'h1234, p, cyc, busy_low);
        checks++;
        if (p !== '0 || cyc !== want_cyc) begin
            errors++;
            $display("FAIL zero_operand: product=%h edges=%0d, want 0 %0d", p, cyc, want_cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] p;
        int cyc, busy_low;
        int gap;
        run_op(16'd7, 16'd9, p, cyc, busy_low);
        checks++;
        if (p !== 32'd63) begin
            errors++;
            $display("FAIL b2b_first: got %0d, want 63", p);
        end
        // Request the next op while still in the DONE cycle.
        bus.start = 1'b1;
        bus.a     = 16'd100;
        bus.b     = 16'd200;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b in IDLE cycle, want 0", bus.busy);
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.product !== 32'd63) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b product=%0d, want 1 63", bus.busy, bus.product);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.product !== 32'd63) begin
            errors++;
            $display("FAIL b2b_hold_in_run: product=%0d, want 63", bus.product);
        end
        wait_done(cyc, busy_low);
        gap = cyc + 2 + 5;
        checks++;
        if (bus.product !== 32'd20000 || gap !== N + 2) begin
            errors++;
            $display("FAIL b2b_second: product=%0d period=%0d, want 20000 %0d",
                     bus.product, gap, N + 2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd3;
        bus.b     = 16'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy: busy=%b before reset, want 1", bus.busy);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b product=%h, want 0 0 0",
                     bus.busy, bus.done, bus.product);
        end
        @(negedge clk);
        reset     = 1'b0;
        done_seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL midrun_lost: %0d cycles with done/busy after reset, want 0",
                     done_seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_max();
        test_start_held();
        test_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
